// File: rtl/logip_pkg.sv
// rtl/logip_pkg.sv - shared types and constants for the logic-analyzer back channel
package logip_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

   localparam int UART_FRAME_BITS = 10;
   localparam int MAX_TX_BYTES    = 4;

   function automatic logic [2:0] clamp_width(input logic [2:0] w);
      return (w > 3'(MAX_TX_BYTES)) ? 3'(MAX_TX_BYTES) : w;
   endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 byte serializer with baud counter
module uart_byte_tx
   import logip_pkg::*;
#(
   parameter int CLK_PER_BIT = 868
) (
   input  logic       clk_i,
   input  logic       rst_in,
   input  logic       stb_i,
   input  logic [7:0] data_i,
   output logic       rdy_o,
   output logic       tx_o
);

   localparam int BW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);
   localparam int DATA_BITS = UART_FRAME_BITS - 2;

   tx_state_t     state, state_n;
   logic [BW-1:0] baud, baud_n;
   logic [2:0]    bit_cnt, bit_n;
   logic [7:0]    shift, shift_n;
   logic          tx, tx_n;
   logic          last;

   assign last  = (baud == BAUD_LAST);
   // Ready during the final stop-bit cycle so the next byte starts with no gap.
   assign rdy_o = (state == IDLE) || ((state == STOP) && last);
   assign tx_o  = tx;

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         state   <= IDLE;
         baud    <= '0;
         bit_cnt <= '0;
         shift   <= '0;
         tx      <= 1'b1;
      end else begin
         state   <= state_n;
         baud    <= baud_n;
         bit_cnt <= bit_n;
         shift   <= shift_n;
         tx      <= tx_n;
      end
   end

   always_comb begin
      state_n = state;
      baud_n  = baud;
      bit_n   = bit_cnt;
      shift_n = shift;
      tx_n    = tx;
      case (state)
         IDLE: begin
            if (stb_i) begin
               state_n = START;
               shift_n = data_i;
               baud_n  = '0;
               tx_n    = 1'b0;
            end
         end
         START: begin
            if (last) begin
               state_n = DATA;
               baud_n  = '0;
               bit_n   = '0;
               tx_n    = shift[0];
               shift_n = shift >> 1;
            end else begin
               baud_n = baud + 1'b1;
            end
         end
         DATA: begin
            if (last) begin
               baud_n = '0;
               if (bit_cnt == 3'(DATA_BITS - 1)) begin
                  state_n = STOP;
                  tx_n    = 1'b1;
               end else begin
                  bit_n   = bit_cnt + 3'd1;
                  tx_n    = shift[0];
                  shift_n = shift >> 1;
               end
            end else begin
               baud_n = baud + 1'b1;
            end
         end
         STOP: begin
            if (last) begin
               baud_n = '0;
               if (stb_i) begin
                  state_n = START;
                  shift_n = data_i;
                  tx_n    = 1'b0;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               baud_n = baud + 1'b1;
            end
         end
         default: begin
            state_n = IDLE;
            baud_n  = '0;
            tx_n    = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/sample_tx.sv
// rtl/sample_tx.sv - word-to-UART transmitter, sends 0..4 bytes per strobe LSB byte first
module sample_tx
   import logip_pkg::*;
#(
   parameter int WIDTH       = 32,
   parameter int CLK_PER_BIT = 868
) (
   input  logic             clk_i,
   input  logic             rst_in,
   input  logic             tx_stb_i,
   input  logic [2:0]       tx_width_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             tx_rdy_o,
   output logic             tx_o
);

   logic             busy;
   logic [2:0]       byte_cnt;
   logic [WIDTH-1:0] word;
   logic [2:0]       n;
   logic             accept;
   logic             byte_stb;
   logic             byte_rdy;
   logic [7:0]       byte_data;

   assign n        = clamp_width(tx_width_i);
   assign accept   = tx_stb_i && !busy;
   assign tx_rdy_o = !busy;

   // First byte bypasses the register so the start bit appears the cycle after the strobe.
   always_comb begin
      byte_stb  = 1'b0;
      byte_data = word[15:8];
      if (accept && (n != 3'd0)) begin
         byte_stb  = 1'b1;
         byte_data = data_i[7:0];
      end else if (busy && byte_rdy && (byte_cnt > 3'd1)) begin
         byte_stb = 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_in) begin
      if (!rst_in) begin
         busy     <= 1'b0;
         byte_cnt <= '0;
         word     <= '0;
      end else if (accept) begin
         word     <= data_i;
         byte_cnt <= n;
         busy     <= (n != 3'd0);
      end else if (busy && byte_rdy) begin
         if (byte_cnt > 3'd1) begin
            word     <= word >> 8;
            byte_cnt <= byte_cnt - 3'd1;
         end else begin
            byte_cnt <= '0;
            busy     <= 1'b0;
         end
      end
   end

   uart_byte_tx #(
      .CLK_PER_BIT(CLK_PER_BIT)
   ) u_byte_tx (
      .clk_i (clk_i),
      .rst_in(rst_in),
      .stb_i (byte_stb),
      .data_i(byte_data),
      .rdy_o (byte_rdy),
      .tx_o  (tx_o)
   );

endmodule
